// File: rtl/iob_uart_pkg.sv
// iob_uart_pkg: shared UART receive-path types and constants
package iob_uart_pkg;
  localparam int UART_BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, WAIT = 2'd2} rx_state_t;
endpackage

// File: rtl/iob_uart_rxfifo_if.sv
// iob_uart_rxfifo_if: core drain handshake plus CPU pop/status port
// to_cyc/to_irq exist only when UART_RXFIFO_TIMEOUT_EN is defined
interface iob_uart_rxfifo_if #(parameter int AW = 4, parameter int TO_W = 20);
  logic core_rdy, core_rd, pop_valid, pop, afull, ovf, ovf_clr;
  logic [iob_uart_pkg::UART_BYTE_W-1:0] core_data, pop_data;
  logic [AW:0] level;
`ifdef UART_RXFIFO_TIMEOUT_EN
  logic [TO_W-1:0] to_cyc;
  logic to_irq;
  modport master (output core_rdy, core_data, pop, ovf_clr, to_cyc,
                  input core_rd, pop_valid, pop_data, level, afull, ovf, to_irq);
  modport slave (input core_rdy, core_data, pop, ovf_clr, to_cyc,
                 output core_rd, pop_valid, pop_data, level, afull, ovf, to_irq);
`else
  if (TO_W < 1) begin : g_to_w
    $error("TO_W must be at least 1");
  end
  modport master (output core_rdy, core_data, pop, ovf_clr,
                  input core_rd, pop_valid, pop_data, level, afull, ovf);
  modport slave (input core_rdy, core_data, pop, ovf_clr,
                 output core_rd, pop_valid, pop_data, level, afull, ovf);
`endif
endinterface

// File: rtl/iob_uart_rxfifo_mem.sv
// iob_uart_rxfifo_mem: 2**AW x byte RAM, one write port, registered write-first read port
module iob_uart_rxfifo_mem
  import iob_uart_pkg::*;
#(parameter int AW = 4) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [UART_BYTE_W-1:0] wd,
  input  logic [AW-1:0]          ra,
  output logic [UART_BYTE_W-1:0] rd
);
  logic [UART_BYTE_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= (we && wa == ra) ? wd : mem[ra];
  end
endmodule

// File: rtl/iob_uart_rxfifo.sv
// iob_uart_rxfifo: drains uart_core rx bytes into a show-ahead FIFO with level, afull and sticky ovf
// UART_RXFIFO_TIMEOUT_EN adds an idle-timeout counter and sticky to_irq
module iob_uart_rxfifo
  import iob_uart_pkg::*;
#(parameter int AW = 4, parameter int AF_MARG = 2, parameter int TO_W = 20) (
  input logic clk,
  input logic arst_n,
  input logic soft_rst,
  iob_uart_rxfifo_if.slave bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(2**AW);
  localparam logic [AW:0] AF_LVL = (AW+1)'(2**AW - AF_MARG);
  rx_state_t state, state_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] level;
  logic [UART_BYTE_W-1:0] hold;
  logic pend, ovf, full, drain, push, pop_fire;
  assign full = level == FULL_LVL;
  assign drain = state == DRAIN;
  assign pop_fire = bus.pop && level != '0;
  // byte captured in DRAIN is written during WAIT so level and read-ahead data appear together
  assign push = state == WAIT && pend;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= IDLE;
    else state <= soft_rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (bus.core_rdy ? DRAIN : IDLE) : state == DRAIN ? WAIT : IDLE;
  always_comb bus.core_rd = drain;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      pend <= 1'b0;
      ovf <= 1'b0;
    end else if (soft_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      pend <= 1'b0;
      ovf <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_fire);
      wr_ptr <= wr_ptr + AW'(push);
      level <= level + (AW+1)'(push) - (AW+1)'(pop_fire);
      pend <= drain && (!full || pop_fire);
      ovf <= (drain && full && !pop_fire) || (ovf && !bus.ovf_clr);
    end
  always_ff @(posedge clk)
    if (drain) hold <= bus.core_data;
  iob_uart_rxfifo_mem #(.AW(AW)) u_mem (
    .clk(clk),
    .we(push),
    .wa(wr_ptr),
    .wd(hold),
    .ra(rd_ptr + AW'(pop_fire)),
    .rd(bus.pop_data)
  );
  assign bus.pop_valid = level != '0;
  assign bus.level = level;
  assign bus.afull = level >= AF_LVL;
  assign bus.ovf = ovf;
`ifdef UART_RXFIFO_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic to_irq;
  assign to_nxt = (push || pop_fire || level == '0) ? '0 : (&to_cnt ? to_cnt : to_cnt + 1'b1);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else if (soft_rst) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else begin
      to_cnt <= to_nxt;
      to_irq <= (to_irq && !pop_fire) || (bus.to_cyc != '0 && to_nxt == bus.to_cyc);
    end
  assign bus.to_irq = to_irq;
`else
  if (TO_W < 1) begin : g_to_w
    $error("TO_W must be at least 1");
  end
`endif
endmodule
